key_entry_ctrl: RTL and testbench
=================================

Name: key_entry_ctrl

Overview:
- Sits behind the 3x4 keypad scanner and consumes its 12-bit one-hot key_data.
- Debounces press and release, then converts each accepted key to a 4-bit code.
- Collects a fixed-length BCD digit entry. '*' clears the entry; '#' submits it.
- Submitted entries go out over a valid/ready handshake to downstream logic (e.g. door-lock compare, display).

Parameters:
- DIGITS, 4: number of BCD digits per entry.
- DEB_CYCLES, 250000: consecutive clk cycles of a stable value needed to accept a press or a release.
- TIMEOUT_CYCLES, 250000000: inactivity limit; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_data  in  12  one-hot from scanner: bit0..8=keys 1..9, bit9='*', bit10='0', bit11='#'; 0 = no key
- key_strobe  out  1  one-cycle pulse when a press is accepted
- key_code  out  4  code of last accepted key: 0-9 digit, 4'hA='*', 4'hB='#'
- digit_count  out  $clog2(DIGITS+1)  digits currently buffered
- entry_data  out  4*DIGITS  submitted entry; first-typed digit in the MS nibble
- entry_valid  out  1  entry available; held until accepted
- entry_ready  in  1  downstream accepts when entry_valid & entry_ready
- entry_err  out  1  one-cycle pulse: '#' pressed with digit_count<DIGITS
- overflow  out  1  one-cycle pulse: digit pressed with digit_count==DIGITS
- timeout  out  1  one-cycle pulse on inactivity clear (0 without the feature)

Behaviour:
- Reset (sync, rst=1 at a posedge): all outputs 0, buffer 0, FSM=IDLE, all counters 0. Takes priority over everything, including a pending entry_valid, which is dropped.
- key_data is valid only if exactly one bit is set. Zero means released. Multi-bit values are invalid and are treated as neither press nor release.
- Debounce FSM:
  - IDLE: on a valid one-hot value, capture it, clear the counter, go to PRESS_DEB.
  - PRESS_DEB: if key_data differs from the captured value, go to IDLE. Otherwise increment; when the counter reaches DEB_CYCLES-1, accept the key and go to HELD. A press is therefore accepted DEB_CYCLES cycles after the first valid sample.
  - HELD: key_data==0 for DEB_CYCLES consecutive cycles goes to IDLE; any nonzero value restarts the count. Holding a key never repeats it. A different key while held is ignored until release.
- Accept action (same cycle as the HELD entry):
  - key_strobe=1 and key_code updated, always.
  - If entry_valid=1, the key is otherwise ignored; buffer is locked.
  - Digit with count<DIGITS: buffer <= {buffer[4*DIGITS-5:0], code}, count+1.
  - Digit with count==DIGITS: overflow pulse, buffer unchanged.
  - '*': buffer and count cleared.
  - '#' with count==DIGITS: entry_data <= buffer, entry_valid=1, buffer and count cleared.
  - '#' with count<DIGITS: entry_err pulse, buffer and count cleared.
- Handshake:
  - entry_valid and entry_data stay stable until the cycle where entry_ready=1; entry_valid clears on the next edge.
  - When a handshake completes in the same cycle as a key accept, the key is still ignored (lock is evaluated on the pre-edge entry_valid).
- Widths: the counter is sized $clog2(DEB_CYCLES). DEB_CYCLES>=2 is required.

Optional Feature:
- Macro: KEY_ENTRY_TIMEOUT_EN.
- Defined:
  - A counter restarts on every accepted key and whenever count==0.
  - When count>0 and TIMEOUT_CYCLES elapse with no accept, the buffer and count clear and timeout pulses one cycle.
  - No timeout while entry_valid=1.
- Undefined: no counter is built; timeout is tied to 0.

Decomposition:
- Package key_entry_pkg holds:
  - Key code localparams: KEY_STAR=4'hA, KEY_HASH=4'hB.
  - FSM state encoding: IDLE, PRESS_DEB, HELD.
  - A function onehot_to_code(12-bit) returning a 4-bit code plus a valid bit.
- Sub-module key_debounce (FSM plus debounce counter) emits an accept pulse and the captured one-hot value. key_entry_ctrl holds the buffer, handshake and timeout.

Test Plan (DEB_CYCLES=4, DIGITS=4, TIMEOUT_CYCLES=20):
- Press '5' (0x010) for 10 cycles, then 0 for 5 -> exactly one key_strobe, key_code=5, digit_count=1, 4 cycles after the press starts.
- Bounce: 0x010 for 2 cycles, 0 for 1, then 0x010 for 6 -> a single accept, timed from the last restart.
- Keys 1,2,3,4,'#' with entry_ready=0 -> entry_valid=1, entry_data=16'h1234, held stable. Press '9' -> key_strobe only, count stays 0. Raise entry_ready -> entry_valid clears next cycle.
- Keys 7,'#' -> entry_err pulse, count=0. Keys 1,2,3,4,5 -> overflow on '5', buffer 16'h1234. '*' -> count=0.
- key_data=0x003 (two bits) held for 10 cycles -> no strobe, FSM stays IDLE. Assert rst during PRESS_DEB -> all outputs 0 next cycle.
- With KEY_ENTRY_TIMEOUT_EN: key 8, then idle 20 cycles -> timeout pulse, count=0. Without it: count stays 1, timeout=0.

Source files
------------

// File: rtl/key_entry_pkg.sv
// -----------------------------------------------------------------------------
// key_entry_pkg
// Shared definitions for the keypad entry controller:
//   - KEY_STAR / KEY_HASH : 4-bit codes of the '*' and '#' keys (digits are 0-9)
//   - deb_state_e         : debounce FSM state encoding
//   - key_dec_t           : decoded key {valid, code}
//   - onehot_to_code()    : scanner one-hot (bit0..8 = 1..9, bit9 = '*',
//                           bit10 = '0', bit11 = '#') to key code; valid only
//                           when exactly one bit is set
// -----------------------------------------------------------------------------
package key_entry_pkg;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2
    } deb_state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } key_dec_t;

    function automatic key_dec_t onehot_to_code(input logic [11:0] onehot);
        key_dec_t   dec;
        logic [3:0] ones;
        dec  = '0;
        ones = '0;
        for (int i = 0; i < 12; i++) begin
            if (onehot[i]) begin
                ones = ones + 4'd1;
                case (i)
                    9:       dec.code = KEY_STAR;
                    10:      dec.code = 4'd0;
                    11:      dec.code = KEY_HASH;
                    default: dec.code = 4'(i + 1);
                endcase
            end
        end
        dec.valid = (ones == 4'd1);
        return dec;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debounces the scanner's one-hot key value for both press and release.
// A press is accepted DEB_CYCLES cycles after the first valid one-hot sample,
// provided the value stays identical; a release needs DEB_CYCLES consecutive
// zero samples. Multi-bit values are neither a press nor a release.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   key_data[11:0]: raw one-hot from the scanner
//   accept        : one-cycle pulse (combinational) on the accepting cycle
//   key_captured  : one-hot value captured at the start of the press
// -----------------------------------------------------------------------------
module key_debounce
    import key_entry_pkg::*;
#(
    parameter int DEB_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] key_data,
    output logic        accept,
    output logic [11:0] key_captured
);

    localparam int            CW       = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    deb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [11:0]   cap_q, cap_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ($onehot(key_data)) begin
                    cap_d   = key_data;
                    cnt_d   = '0;
                    state_d = PRESS_DEB;
                end
            end
            PRESS_DEB: begin
                if (key_data != cap_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                // Any nonzero value, even another key, only restarts the
                // release count: holding never repeats and rollover is ignored.
                if (key_data != '0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_captured = cap_q;

endmodule

// File: rtl/key_entry_ctrl.sv
// -----------------------------------------------------------------------------
// key_entry_ctrl
// Keypad entry controller: debounces scanner keys, collects DIGITS BCD digits
// ('*' clears, '#' submits) and hands complete entries downstream over a
// valid/ready handshake. New keys are ignored while an entry is pending.
// Optional feature (macro KEY_ENTRY_TIMEOUT_EN): a partial entry is cleared
// after TIMEOUT_CYCLES cycles without an accepted key; otherwise timeout = 0.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   key_data[11:0]    : one-hot key from the scanner, 0 = no key
//   key_strobe        : one-cycle pulse per accepted press
//   key_code[3:0]     : code of the last accepted key (0-9, A='*', B='#')
//   digit_count       : digits currently buffered
//   entry_data        : submitted entry, first-typed digit in the MS nibble
//   entry_valid/ready : output handshake; valid held until ready
//   entry_err         : pulse, '#' on an incomplete entry
//   overflow          : pulse, digit on a full buffer
//   timeout           : pulse, inactivity clear
// -----------------------------------------------------------------------------
module key_entry_ctrl
    import key_entry_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DEB_CYCLES     = 250000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [11:0]                  key_data,
    output logic                         key_strobe,
    output logic [3:0]                   key_code,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic [4*DIGITS-1:0]          entry_data,
    output logic                         entry_valid,
    input  logic                         entry_ready,
    output logic                         entry_err,
    output logic                         overflow,
    output logic                         timeout
);

    localparam int              NW   = 4 * DIGITS;
    localparam int              CNTW = $clog2(DIGITS + 1);
    localparam logic [CNTW-1:0] FULL = CNTW'(DIGITS);

    logic        deb_accept;
    logic [11:0] deb_key;
    key_dec_t    dec;
    logic        key_accept;
    logic        tmo_fire;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .key_data     (key_data),
        .accept       (deb_accept),
        .key_captured (deb_key)
    );

    assign dec        = onehot_to_code(deb_key);
    assign key_accept = deb_accept & dec.valid;

    logic            key_strobe_q, key_strobe_d;
    logic [3:0]      key_code_q, key_code_d;
    logic [NW-1:0]   buf_q, buf_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [NW-1:0]   entry_data_q, entry_data_d;
    logic            entry_valid_q, entry_valid_d;
    logic            entry_err_q, entry_err_d;
    logic            overflow_q, overflow_d;
    logic            timeout_q, timeout_d;

`ifdef KEY_ENTRY_TIMEOUT_EN
    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_fire  = 1'b0;
        if (key_accept || count_q == '0 || entry_valid_q) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_LAST) begin
            tmo_fire  = 1'b1;
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_fire           = 1'b0;
`endif

    always_comb begin
        key_strobe_d  = key_accept;
        key_code_d    = key_code_q;
        buf_d         = buf_q;
        count_d       = count_q;
        entry_data_d  = entry_data_q;
        entry_valid_d = entry_valid_q;
        entry_err_d   = 1'b0;
        overflow_d    = 1'b0;
        timeout_d     = tmo_fire;

        if (entry_valid_q && entry_ready) entry_valid_d = 1'b0;

        if (tmo_fire) begin
            buf_d   = '0;
            count_d = '0;
        end

        if (key_accept) begin
            key_code_d = dec.code;
            // Lock uses the pre-edge entry_valid, so a key landing on the
            // handshake cycle is still dropped.
            if (!entry_valid_q) begin
                if (dec.code <= 4'd9) begin
                    if (count_q == FULL) begin
                        overflow_d = 1'b1;
                    end else begin
                        buf_d   = NW'({buf_q, dec.code});
                        count_d = count_q + CNTW'(1);
                    end
                end else begin
                    if (dec.code == KEY_HASH) begin
                        if (count_q == FULL) begin
                            entry_data_d  = buf_q;
                            entry_valid_d = 1'b1;
                        end else begin
                            entry_err_d = 1'b1;
                        end
                    end
                    buf_d   = '0;
                    count_d = '0;
                end
            end
        end
    end

    // NOTE: the digit buffer and entry register are reset along with the
    // control flops; they are a few flops, not a RAM, and a reset must drop
    // any partial or pending entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_strobe_q  <= 1'b0;
            key_code_q    <= '0;
            buf_q         <= '0;
            count_q       <= '0;
            entry_data_q  <= '0;
            entry_valid_q <= 1'b0;
            entry_err_q   <= 1'b0;
            overflow_q    <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            key_strobe_q  <= key_strobe_d;
            key_code_q    <= key_code_d;
            buf_q         <= buf_d;
            count_q       <= count_d;
            entry_data_q  <= entry_data_d;
            entry_valid_q <= entry_valid_d;
            entry_err_q   <= entry_err_d;
            overflow_q    <= overflow_d;
            timeout_q     <= timeout_d;
        end
    end

    assign key_strobe  = key_strobe_q;
    assign key_code    = key_code_q;
    assign digit_count = count_q;
    assign entry_data  = entry_data_q;
    assign entry_valid = entry_valid_q;
    assign entry_err   = entry_err_q;
    assign overflow    = overflow_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_entry_ctrl
// Scoreboard bench for key_entry_ctrl (DIGITS=4, DEB_CYCLES=4,
// TIMEOUT_CYCLES=20). The stimulus side feeds a key-level model that pushes
// expected events; a negedge monitor pops and compares whenever the DUT
// raises key_strobe, entry_err, overflow, timeout or completes a handshake.
// -----------------------------------------------------------------------------
module tb_key_entry_ctrl;

    localparam int DIGITS  = 4;
    localparam int DEB     = 4;
    localparam int TIMEOUT = 20;
    localparam int CNTW    = $clog2(DIGITS + 1);

    typedef enum int {EV_NONE, EV_KEY, EV_ERR, EV_OVF, EV_TMO} ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        int       code;
        int       count;
        int       cyc;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [11:0]          key_data;
    logic                 key_strobe;
    logic [3:0]           key_code;
    logic [CNTW-1:0]      digit_count;
    logic [4*DIGITS-1:0]  entry_data;
    logic                 entry_valid;
    logic                 entry_ready;
    logic                 entry_err;
    logic                 overflow;
    logic                 timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Key-level reference model state.
    ev_t ev_q[$];
    int  entry_q[$];
    int  digits[$];
    bit  locked = 1'b0;

    logic            prev_valid = 1'b0;
    logic            prev_ready = 1'b0;
    logic            prev_rst   = 1'b1;
    logic [4*DIGITS-1:0] prev_data = '0;

    key_entry_ctrl #(
        .DIGITS         (DIGITS),
        .DEB_CYCLES     (DEB),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_data    (key_data),
        .key_strobe  (key_strobe),
        .key_code    (key_code),
        .digit_count (digit_count),
        .entry_data  (entry_data),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .entry_err   (entry_err),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // k: 0-9 digits, 10 = '*', 11 = '#'
    function automatic logic [11:0] key_bits(input int k);
        logic [11:0] b;
        b = '0;
        if (k >= 1 && k <= 9) b[k-1] = 1'b1;
        else if (k == 0)      b[10]  = 1'b1;
        else if (k == 10)     b[9]   = 1'b1;
        else                  b[11]  = 1'b1;
        return b;
    endfunction

    // Entry rules applied to one accepted key; acc = cycle the strobe shows.
    task automatic model_press(input int k, input int acc);
        ev_t e;
        ev_t x;
        int  val;
        x.kind = EV_NONE;
        x.code = k;
        x.cyc  = acc;
        x.count = 0;
        if (!locked) begin
            if (k <= 9) begin
                if (digits.size() < DIGITS) digits.push_back(k);
                else x.kind = EV_OVF;
            end else if (k == 10) begin
                digits.delete();
            end else begin
                if (digits.size() == DIGITS) begin
                    val = 0;
                    foreach (digits[i]) val = val * 16 + digits[i];
                    entry_q.push_back(val);
                    locked = 1'b1;
                end else begin
                    x.kind = EV_ERR;
                end
                digits.delete();
            end
        end
        e.kind  = EV_KEY;
        e.code  = k;
        e.count = digits.size();
        e.cyc   = acc;
        ev_q.push_back(e);
        if (x.kind != EV_NONE) ev_q.push_back(x);
    endtask

    task automatic press_key(input int k, input int hold, input int gap);
        model_press(k, cyc + 1 + DEB);
        key_data = key_bits(k);
        tick(hold);
        key_data = '0;
        tick(gap);
    endtask

    task automatic press_std(input int k);
        press_key(k, DEB + 2, DEB + 2);
    endtask

    task automatic handshake(input int wait_cycles);
        tick(wait_cycles);
        check("valid_before_handshake", entry_valid, 1);
        entry_ready = 1'b1;
        tick(1);
        entry_ready = 1'b0;
        locked      = 1'b0;
        check("valid_after_handshake", entry_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_key_strobe"},  key_strobe, 0);
        check({tag, "_key_code"},    key_code, 0);
        check({tag, "_digit_count"}, digit_count, 0);
        check({tag, "_entry_data"},  entry_data, 0);
        check({tag, "_entry_valid"}, entry_valid, 0);
        check({tag, "_entry_err"},   entry_err, 0);
        check({tag, "_overflow"},    overflow, 0);
        check({tag, "_timeout"},     timeout, 0);
    endtask

    function automatic ev_t pop_ev();
        ev_t e;
        e.kind = EV_NONE;
        e.code = 0;
        e.count = 0;
        e.cyc = 0;
        if (ev_q.size() > 0) e = ev_q.pop_front();
        return e;
    endfunction

    task automatic expect_event(input ev_kind_e seen, input string name);
        ev_t e;
        e = pop_ev();
        check({name, "_event_kind"}, seen, e.kind);
        if (e.kind == seen) begin
            check({name, "_cycle"}, cyc, e.cyc);
            if (seen == EV_KEY) begin
                check("key_code", key_code, e.code);
                check("digit_count", digit_count, e.count);
            end
        end
    endtask

    task automatic monitor_cycle();
        logic [63:0] exp_data;
        if (!rst) begin
            if (key_strobe) expect_event(EV_KEY, "strobe");
            if (entry_err)  expect_event(EV_ERR, "entry_err");
            if (overflow)   expect_event(EV_OVF, "overflow");
            if (timeout)    expect_event(EV_TMO, "timeout");
            if (entry_valid && entry_ready) begin
                exp_data = 64'hDEAD_0000_0000;
                if (entry_q.size() > 0) exp_data = 64'(entry_q.pop_front());
                check("entry_data", entry_data, exp_data);
            end
            if (prev_valid && !prev_ready && !prev_rst) begin
                check("valid_held", entry_valid, 1);
                check("data_held", entry_data, prev_data);
            end
        end
    endtask

    always @(negedge clk) begin
        monitor_cycle();
        prev_valid <= entry_valid;
        prev_ready <= entry_ready;
        prev_data  <= entry_data;
        prev_rst   <= rst;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int k;
        rst         = 1'b1;
        key_data    = '0;
        entry_ready = 1'b0;
        tick(3);
        check_all_zero("in_reset");
        rst = 1'b0;
        tick(2);
        check_all_zero("after_reset");

        // Single press of '5': 10 cycles held, 5 released.
        press_key(5, 10, 5);
        check("count_after_5", digit_count, 1);

        // Bounce: the accept is timed from the last restart.
        key_data = key_bits(5);
        tick(2);
        key_data = '0;
        tick(1);
        model_press(5, cyc + 1 + DEB);
        key_data = key_bits(5);
        tick(6);
        key_data = '0;
        tick(DEB + 2);
        check("count_after_bounce", digit_count, 2);
        press_std(10);

        // Full entry held with entry_ready low, then a locked key.
        press_std(1);
        press_std(2);
        press_std(3);
        press_std(4);
        press_std(11);
        tick(5);
        check("entry_valid_pending", entry_valid, 1);
        press_std(9);
        check("count_locked", digit_count, 0);
        handshake(2);

        // Incomplete submit, overflow, buffer preserved, clear.
        press_std(7);
        press_std(11);
        check("count_after_err", digit_count, 0);
        press_std(1);
        press_std(2);
        press_std(3);
        press_std(4);
        press_std(5);
        check("count_after_overflow", digit_count, DIGITS);
        press_std(11);
        handshake(1);
        press_std(6);
        press_std(10);
        check("count_after_star", digit_count, 0);

        // Two-bit value never arms the debouncer; a clean '*' straight after
        // is accepted exactly DEB cycles from its first sample.
        key_data = 12'h003;
        tick(10);
        model_press(10, cyc + 1 + DEB);
        key_data = key_bits(10);
        tick(DEB + 2);
        key_data = '0;
        tick(DEB + 2);

        // Randomized key sequence.
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 15);
            if (r < 10)      k = r;
            else if (r < 12) k = 10;
            else             k = 11;
            press_key(k, $urandom_range(DEB + 2, DEB + 4), $urandom_range(DEB + 2, DEB + 5));
            if (locked && ($urandom_range(0, 1) == 1)) handshake($urandom_range(0, 3));
        end
        if (locked) handshake(1);
        press_std(10);

        // Inactivity with one buffered digit.
`ifdef KEY_ENTRY_TIMEOUT_EN
        begin
            ev_t t;
            model_press(8, cyc + 1 + DEB);
            t.kind  = EV_TMO;
            t.code  = 0;
            t.count = 0;
            t.cyc   = cyc + 1 + DEB + TIMEOUT;
            ev_q.push_back(t);
            key_data = key_bits(8);
            tick(DEB + 2);
            key_data = '0;
            tick(TIMEOUT + 5);
            digits.delete();
            check("count_after_timeout", digit_count, 0);
        end
`else
        press_key(8, DEB + 2, TIMEOUT + 5);
        check("count_no_timeout", digit_count, 1);
        check("timeout_low", timeout, 0);
        press_std(10);
`endif

        // Reset mid-debounce with an entry pending: everything is dropped.
        press_std(1);
        press_std(2);
        press_std(3);
        press_std(4);
        press_std(11);
        check("entry_valid_before_rst", entry_valid, 1);
        key_data = key_bits(3);
        tick(2);
        rst      = 1'b1;
        key_data = '0;
        tick(1);
        check_all_zero("mid_press_reset");
        rst = 1'b0;
        digits.delete();
        entry_q.delete();
        locked = 1'b0;
        tick(DEB + 3);
        check("entry_valid_after_rst", entry_valid, 0);
        check("count_after_rst", digit_count, 0);

        tick(10);
        check("events_outstanding", ev_q.size(), 0);
        check("entries_outstanding", entry_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
